// File: rtl/alu_arbiter_if.sv
`default_nettype none
// ==================================================================
// alu_arbiter_if : requester request/response and shared-ALU bus
// Rev 1.0
// ==================================================================
interface alu_arbiter_if #(
  parameter int DATA_WIDTH   = 16,
  parameter int OPCODE_WIDTH = 4
);
  logic [1:0]                req_valid;
  logic [1:0]                req_ready;
  logic [2*OPCODE_WIDTH-1:0] req_opcode;
  logic [2*DATA_WIDTH-1:0]   req_op_a;
  logic [2*DATA_WIDTH-1:0]   req_op_b;
  logic [1:0]                rsp_valid;
  logic [1:0]                rsp_ready;
  logic [DATA_WIDTH-1:0]     rsp_result;
  logic [2:0]                rsp_flags;
  logic [DATA_WIDTH-1:0]     alu_op_a;
  logic [DATA_WIDTH-1:0]     alu_op_b;
  logic [OPCODE_WIDTH-1:0]   alu_opcode;
  logic                      alu_active;
  logic [DATA_WIDTH-1:0]     alu_result;
  logic                      alu_equal;
  logic                      alu_less;
  logic                      alu_greater;

  modport slave (
    input  req_valid, req_opcode, req_op_a, req_op_b, rsp_ready,
           alu_result, alu_equal, alu_less, alu_greater,
    output req_ready, rsp_valid, rsp_result, rsp_flags,
           alu_op_a, alu_op_b, alu_opcode, alu_active
  );

  modport master (
    output req_valid, req_opcode, req_op_a, req_op_b, rsp_ready,
           alu_result, alu_equal, alu_less, alu_greater,
    input  req_ready, rsp_valid, rsp_result, rsp_flags,
           alu_op_a, alu_op_b, alu_opcode, alu_active
  );
endinterface
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// ==================================================================
// alu_arbiter : two-requester round-robin front end for a shared ALU
// Rev 1.0
// ==================================================================
module alu_arbiter #(
  parameter int DATA_WIDTH   = 16,
  parameter int OPCODE_WIDTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  alu_arbiter_if.slave bus
);
  localparam logic [OPCODE_WIDTH-1:0] OP_CMP = OPCODE_WIDTH'(4'b1000);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    CMP_WAIT = 2'd2,
    RESP     = 2'd3
  } state_t;

  state_t                  state;
  state_t                  state_nxt;
  logic                    ptr;
  logic                    grant;
  logic                    grant_sel;
  logic                    accept;
  logic                    rsp_done;
  logic [OPCODE_WIDTH-1:0] opcode;
  logic [DATA_WIDTH-1:0]   op_a;
  logic [DATA_WIDTH-1:0]   op_b;
  logic [DATA_WIDTH-1:0]   result;
  logic [2:0]              flags;

  // A lone requester always wins; the pointer only breaks ties.
  always_comb begin
    grant_sel = ptr;
    if (bus.req_valid == 2'b01) begin
      grant_sel = 1'b0;
    end else if (bus.req_valid == 2'b10) begin
      grant_sel = 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    rsp_done  = 1'b0;
    case (state)
      IDLE: begin
        if (|bus.req_valid) begin
          accept    = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        state_nxt = (opcode == OP_CMP) ? CMP_WAIT : RESP;
      end
      CMP_WAIT: begin
        state_nxt = RESP;
      end
      RESP: begin
        if (bus.rsp_ready[grant]) begin
          rsp_done  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      ptr    <= 1'b0;
      grant  <= 1'b0;
      opcode <= '0;
      op_a   <= '0;
      op_b   <= '0;
      result <= '0;
      flags  <= 3'b000;
    end else begin
      state <= state_nxt;
      if (accept) begin
        grant  <= grant_sel;
        opcode <= grant_sel ? bus.req_opcode[2*OPCODE_WIDTH-1:OPCODE_WIDTH]
                            : bus.req_opcode[OPCODE_WIDTH-1:0];
        op_a   <= grant_sel ? bus.req_op_a[2*DATA_WIDTH-1:DATA_WIDTH]
                            : bus.req_op_a[DATA_WIDTH-1:0];
        op_b   <= grant_sel ? bus.req_op_b[2*DATA_WIDTH-1:DATA_WIDTH]
                            : bus.req_op_b[DATA_WIDTH-1:0];
      end
      if (state == ISSUE && opcode != OP_CMP) begin
        result <= bus.alu_result;
        flags  <= 3'b000;
      end
      // Compare flags are registered inside the ALU, so they arrive one cycle late.
      if (state == CMP_WAIT) begin
        result <= '0;
        flags  <= {bus.alu_greater, bus.alu_less, bus.alu_equal};
      end
      if (rsp_done) begin
        ptr <= ~grant;
      end
    end
  end

  assign bus.req_ready  = rst ? 2'b00 : {accept & grant_sel, accept & ~grant_sel};
  assign bus.rsp_valid  = (rst || state != RESP) ? 2'b00 : {grant, ~grant};
  assign bus.alu_active = ~rst && (state == ISSUE);
  assign bus.alu_op_a   = op_a;
  assign bus.alu_op_b   = op_b;
  assign bus.alu_opcode = opcode;
  assign bus.rsp_result = result;
  assign bus.rsp_flags  = flags;
endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ==================================================================
// tb_alu_arbiter : random + directed self-checking bench for alu_arbiter
// Rev 1.0
// ==================================================================
module tb_alu_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_pass   = 0;
  int   n_checks = 0;

  always #5 clk = ~clk;

  alu_arbiter_if #(.DATA_WIDTH(16), .OPCODE_WIDTH(4)) bif ();

  alu_arbiter #(.DATA_WIDTH(16), .OPCODE_WIDTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  // Shared ALU: 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 shl1, 6 shr1, 7 negate, 8 compare, others 0
  function automatic logic [15:0] alu_fn(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    case (op)
      4'h0:    return a + b;
      4'h1:    return a - b;
      4'h2:    return a & b;
      4'h3:    return a | b;
      4'h4:    return a ^ b;
      4'h5:    return a << 1;
      4'h6:    return a >> 1;
      4'h7:    return 16'h0000 - a;
      default: return 16'h0000;
    endcase
  endfunction

  assign bif.alu_result = alu_fn(bif.alu_opcode, bif.alu_op_a, bif.alu_op_b);

  always @(posedge clk) begin
    if (bif.alu_active) begin
      bif.alu_greater <= bif.alu_op_a > bif.alu_op_b;
      bif.alu_less    <= bif.alu_op_a < bif.alu_op_b;
      bif.alu_equal   <= bif.alu_op_a == bif.alu_op_b;
    end else begin
      bif.alu_greater <= 1'b0;
      bif.alu_less    <= 1'b0;
      bif.alu_equal   <= 1'b0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  // Transaction-level reference: one transaction in flight, response 2 or 3 cycles after accept.
  logic        m_busy = 1'b0;
  int          m_age  = 0;
  logic        m_g    = 1'b0;
  logic        m_ptr  = 1'b0;
  logic [3:0]  m_op   = 4'h0;
  logic [15:0] m_a    = 16'h0;
  logic [15:0] m_b    = 16'h0;
  logic        m_sel;
  logic [1:0]  e_ready;
  logic [1:0]  e_rsp;
  logic        e_act;

  always @(negedge clk) begin
    e_ready = 2'b00;
    e_rsp   = 2'b00;
    e_act   = 1'b0;
    m_sel   = 1'b0;
    if (rst) begin
      chk("m_rst_req_ready", 32'(bif.req_ready), 32'h0);
      chk("m_rst_rsp_valid", 32'(bif.rsp_valid), 32'h0);
      chk("m_rst_alu_active", 32'(bif.alu_active), 32'h0);
      m_busy = 1'b0;
      m_ptr  = 1'b0;
      m_op   = 4'h0;
      m_a    = 16'h0;
      m_b    = 16'h0;
    end else begin
      if (m_busy) begin
        e_act = (m_age == 1);
        if (m_age >= ((m_op == 4'b1000) ? 3 : 2)) e_rsp = {m_g, ~m_g};
      end else if (bif.req_valid != 2'b00) begin
        m_sel   = (bif.req_valid == 2'b11) ? m_ptr : bif.req_valid[1];
        e_ready = {m_sel, ~m_sel};
      end
      chk("m_req_ready", 32'(bif.req_ready), 32'(e_ready));
      chk("m_rsp_valid", 32'(bif.rsp_valid), 32'(e_rsp));
      chk("m_alu_active", 32'(bif.alu_active), 32'(e_act));
      chk("m_alu_op_a", 32'(bif.alu_op_a), 32'(m_a));
      chk("m_alu_op_b", 32'(bif.alu_op_b), 32'(m_b));
      chk("m_alu_opcode", 32'(bif.alu_opcode), 32'(m_op));
      if (e_rsp != 2'b00) begin
        if (m_op == 4'b1000) begin
          chk("m_rsp_result", 32'(bif.rsp_result), 32'h0);
          chk("m_rsp_flags", 32'(bif.rsp_flags), 32'({m_a > m_b, m_a < m_b, m_a == m_b}));
        end else begin
          chk("m_rsp_result", 32'(bif.rsp_result), 32'(alu_fn(m_op, m_a, m_b)));
          chk("m_rsp_flags", 32'(bif.rsp_flags), 32'h0);
        end
      end
      if (m_busy) begin
        if (e_rsp != 2'b00 && bif.rsp_ready[m_g]) begin
          m_busy = 1'b0;
          m_ptr  = ~m_g;
        end else begin
          m_age++;
        end
      end else if (bif.req_valid != 2'b00) begin
        m_busy = 1'b1;
        m_age  = 1;
        m_g    = m_sel;
        m_op   = m_sel ? bif.req_opcode[7:4] : bif.req_opcode[3:0];
        m_a    = m_sel ? bif.req_op_a[31:16] : bif.req_op_a[15:0];
        m_b    = m_sel ? bif.req_op_b[31:16] : bif.req_op_b[15:0];
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    bif.req_valid[i]         = 1'b1;
    bif.req_opcode[i*4 +: 4] = op;
    bif.req_op_a[i*16 +: 16] = a;
    bif.req_op_b[i*16 +: 16] = b;
  endtask

  task automatic drain();
    bif.req_valid = 2'b00;
    bif.rsp_ready = 2'b11;
    repeat (5) tick();
  endtask

  // Single-requester transaction with hand-computed response.
  task automatic xact(input string nm, input int i, input logic [3:0] op, input logic [15:0] a,
                      input logic [15:0] b, input logic [15:0] er, input logic [2:0] ef);
    set_req(i, op, a, b);
    bif.rsp_ready = 2'b11;
    @(negedge clk);
    chk({nm, "_ready"}, 32'(bif.req_ready), (i == 1) ? 32'h2 : 32'h1);
    tick();
    bif.req_valid = 2'b00;
    @(negedge clk);
    chk({nm, "_active"}, 32'(bif.alu_active), 32'h1);
    tick();
    if (op == 4'b1000) begin
      @(negedge clk);
      chk({nm, "_early"}, 32'(bif.rsp_valid), 32'h0);
      tick();
    end
    @(negedge clk);
    chk({nm, "_valid"}, 32'(bif.rsp_valid), (i == 1) ? 32'h2 : 32'h1);
    chk({nm, "_result"}, 32'(bif.rsp_result), 32'(er));
    chk({nm, "_flags"}, 32'(bif.rsp_flags), 32'(ef));
    tick();
  endtask

  int gr[4];
  int n_gr;

  initial begin
    bif.req_valid  = 2'b00;
    bif.req_opcode = '0;
    bif.req_op_a   = '0;
    bif.req_op_b   = '0;
    bif.rsp_ready  = 2'b00;
    rst = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    chk("reset_req_ready", 32'(bif.req_ready), 32'h0);
    chk("reset_rsp_valid", 32'(bif.rsp_valid), 32'h0);
    chk("reset_alu_active", 32'(bif.alu_active), 32'h0);
    tick();
    rst = 1'b0;

    xact("add", 0, 4'b0000, 16'h0003, 16'h0004, 16'h0007, 3'b000);
    xact("cmp", 1, 4'b1000, 16'h0005, 16'h0009, 16'h0000, 3'b010);
    xact("neg0", 0, 4'b0111, 16'h0000, 16'h1234, 16'h0000, 3'b000);
    xact("neg8000", 1, 4'b0111, 16'h8000, 16'h0001, 16'h8000, 3'b000);
    xact("hi_op", 0, 4'b1101, 16'h1111, 16'h2222, 16'h0000, 3'b000);

    // Round-robin straight after reset
    rst = 1'b1;
    tick();
    rst = 1'b0;
    set_req(0, 4'b0000, 16'h0010, 16'h0020);
    set_req(1, 4'b0000, 16'h0100, 16'h0200);
    bif.rsp_ready = 2'b11;
    n_gr = 0;
    for (int k = 0; k < 4; k++) gr[k] = -1;
    for (int c = 0; c < 40 && n_gr < 4; c++) begin
      @(negedge clk);
      if (bif.req_ready != 2'b00) begin
        gr[n_gr] = int'(bif.req_ready[1]);
        n_gr++;
      end
      tick();
    end
    chk("rr_count", 32'(n_gr), 32'd4);
    chk("rr_grant0", 32'(gr[0]), 32'd0);
    chk("rr_grant1", 32'(gr[1]), 32'd1);
    chk("rr_grant2", 32'(gr[2]), 32'd0);
    chk("rr_grant3", 32'(gr[3]), 32'd1);
    drain();

    // Backpressure; rsp_ready on the non-granted bit must be ignored
    bif.rsp_ready = 2'b10;
    set_req(0, 4'b0001, 16'h0010, 16'h0001);
    @(negedge clk);
    chk("bp_ready", 32'(bif.req_ready), 32'h1);
    tick();
    bif.req_valid = 2'b00;
    set_req(1, 4'b0000, 16'h0002, 16'h0003);
    @(negedge clk);
    chk("bp_issue_ready", 32'(bif.req_ready), 32'h0);
    tick();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("bp_valid", 32'(bif.rsp_valid), 32'h1);
      chk("bp_result", 32'(bif.rsp_result), 32'h000F);
      chk("bp_hold_ready", 32'(bif.req_ready), 32'h0);
      tick();
    end
    bif.rsp_ready = 2'b01;
    @(negedge clk);
    chk("bp_hs_valid", 32'(bif.rsp_valid), 32'h1);
    tick();
    @(negedge clk);
    chk("bp_reaccept", 32'(bif.req_ready), 32'h2);
    tick();
    drain();

    // Reset during CMP_WAIT; pointer left at 1 beforehand
    xact("pre", 0, 4'b0000, 16'h0001, 16'h0002, 16'h0003, 3'b000);
    set_req(0, 4'b1000, 16'h0007, 16'h0007);
    tick();
    bif.req_valid = 2'b00;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    set_req(0, 4'b0000, 16'h0001, 16'h0001);
    set_req(1, 4'b0000, 16'h0001, 16'h0001);
    @(negedge clk);
    chk("rmc_rsp_valid", 32'(bif.rsp_valid), 32'h0);
    chk("rmc_alu_active", 32'(bif.alu_active), 32'h0);
    chk("rmc_ptr_grant", 32'(bif.req_ready), 32'h1);
    tick();
    drain();

    // Random traffic against the reference model
    for (int c = 0; c < 600; c++) begin
      rst            = ($urandom_range(0, 79) == 0);
      bif.req_valid  = 2'($urandom);
      bif.rsp_ready  = 2'($urandom);
      bif.req_opcode = ($urandom_range(0, 3) == 0) ? 8'h88 : 8'($urandom);
      bif.req_op_a   = ($urandom_range(0, 3) == 0) ? 32'h00050005 : $urandom;
      bif.req_op_b   = ($urandom_range(0, 3) == 0) ? 32'h00050005 : $urandom;
      tick();
    end
    rst = 1'b0;
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 16, giving the operand and result width.
REQ-002 The block SHALL have parameter OPCODE_WIDTH, default 4, giving the ALU opcode width.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 req_valid  input  2  per-requester request valid; bit i belongs to requester i.
REQ-006 req_ready  output  2  per-requester accept pulse; a request is accepted when valid and ready are both 1.
REQ-007 req_opcode  input  2*OPCODE_WIDTH  packed opcodes; requester i uses slice [i*OPCODE_WIDTH +: OPCODE_WIDTH].
REQ-008 req_op_a, req_op_b  input  2*DATA_WIDTH each  packed operands, sliced per requester in the same way.
REQ-009 rsp_valid  output  2  per-requester response valid.
REQ-010 rsp_ready  input  2  per-requester response accept.
REQ-011 rsp_result  output  DATA_WIDTH  response result, shared by both requesters and meaningful only for the requester whose rsp_valid bit is set.
REQ-012 rsp_flags  output  3  {greater, less, equal} for compare operations; 3'b000 for all other operations.
REQ-013 alu_op_a, alu_op_b  output  DATA_WIDTH each  operands driven to the shared ALU.
REQ-014 alu_opcode  output  OPCODE_WIDTH  opcode driven to the ALU.
REQ-015 alu_active  output  1  ALU enable, which qualifies the flag update.
REQ-016 alu_result  input  DATA_WIDTH  combinational ALU result.
REQ-017 alu_equal, alu_less, alu_greater  input  1 each  registered ALU flags; they are valid in the cycle after alu_active=1 and read 0 otherwise.

Function
REQ-018 The block SHALL implement the FSM states IDLE, ISSUE, CMP_WAIT and RESP.
REQ-019 In IDLE, when any req_valid bit is set, the block SHALL select a grant g, assert req_ready[g] for exactly that cycle, latch g together with g's opcode and operands, and move to ISSUE.
REQ-020 Arbitration SHALL be round-robin with a 1-bit priority pointer: if only one requester is valid, that requester wins; if both are valid, the requester named by the pointer wins.
REQ-021 The priority pointer SHALL be set to the other requester (not g) when a response handshake completes.
REQ-022 req_ready SHALL be 2'b00 in every state except the accept cycle in IDLE.
REQ-023 alu_op_a, alu_op_b and alu_opcode SHALL always drive the latched transaction registers.
REQ-024 alu_active SHALL be 1 only in ISSUE.
REQ-025 In ISSUE, for an opcode other than 4'b1000, the block SHALL capture alu_result into rsp_result, set rsp_flags to 3'b000, and move to RESP.
REQ-026 In ISSUE, for opcode 4'b1000 (compare), the block SHALL move to CMP_WAIT without capturing anything.
REQ-027 In CMP_WAIT, the block SHALL capture {alu_greater, alu_less, alu_equal} into rsp_flags, set rsp_result to 0, and move to RESP.
REQ-028 Opcodes 4'b1001 through 4'b1111 SHALL be handled as non-compare operations, returning whatever alu_result holds (0 for the current ALU).
REQ-029 In RESP, rsp_valid[g] SHALL be 1 and the other bit 0; rsp_result and rsp_flags SHALL be held stable until rsp_ready[g]=1, at which point the block returns to IDLE.
REQ-030 rsp_ready on the non-granted bit SHALL be ignored.
REQ-031 Latency SHALL be fixed: with an accept in cycle T, rsp_valid rises in T+2 for non-compare operations and in T+3 for compare.
REQ-032 The earliest next accept SHALL be in the cycle after the response handshake, since IDLE is re-entered first; no new request is accepted while a transaction is in flight.
REQ-033 A requester that drops req_valid before being granted SHALL simply lose that request; the block keeps no request queue.

Reset
REQ-034 With rst=1 at a clock edge, the FSM SHALL go to IDLE, the pointer to 0, and the latched opcode, operands, result and flags to 0.
REQ-035 While in reset, req_ready, rsp_valid and alu_active SHALL be 0.
REQ-036 A reset applied in mid-transaction (ISSUE, CMP_WAIT or RESP) SHALL discard the transaction with no response issued.
REQ-037 The first accept after reset SHALL occur no earlier than the first cycle with rst=0.

Verification
REQ-038 The bench SHALL cover a single add: req0 opcode 0000, a=0x0003, b=0x0004 -> req_ready=01 at T, alu_active=1 at T+1, rsp_valid=01 at T+2 with rsp_result=0x0007 and rsp_flags=000.
REQ-039 The bench SHALL cover a compare: req1 opcode 1000, a=0x0005, b=0x0009 -> rsp_valid=10 at T+3 with rsp_flags=010 and rsp_result=0x0000.
REQ-040 The bench SHALL cover round-robin: both requesters valid continuously with opcode 0000 after reset -> grants in the order 0,1,0,1, and each rsp_valid bit matches its grant.
REQ-041 The bench SHALL cover backpressure: rsp_ready held at 0 for 5 cycles during a subtract of 0x0010 and 0x0001 -> rsp_valid stays set with rsp_result=0x000F stable, req_ready=00 throughout, and IDLE is re-entered the cycle after rsp_ready=1.
REQ-042 The bench SHALL cover reset mid-compare: rst=1 during CMP_WAIT -> next cycle state is IDLE, rsp_valid=00, alu_active=0, and the pointer is 0.
REQ-043 The bench SHALL cover a negate boundary: opcode 0111 with a=0x0000 -> rsp_result=0x0000; opcode 0111 with a=0x8000 -> rsp_result=0x8000.
